// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the rhythm game mode controller.
//   mode_t      : encoding of the mode output seen by display/audio/scoring.
//   ST_*        : the same encodings as plain 3-bit constants for the FSM.
//                 The state register must be able to hold the illegal value 0,
//                 so the FSM uses a bare logic [2:0] vector rather than the enum.
//   BTN_*       : which physical button plays which role.
// ----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE   = 3'd1,
        MODE_EDIT   = 3'd2,
        MODE_DIFF   = 3'd3,
        MODE_RUN    = 3'd4,
        MODE_PAUSE  = 3'd5,
        MODE_FINISH = 3'd6,
        MODE_COUNT  = 3'd7
    } mode_t;

    localparam logic [2:0] ST_IDLE   = MODE_IDLE;
    localparam logic [2:0] ST_EDIT   = MODE_EDIT;
    localparam logic [2:0] ST_DIFF   = MODE_DIFF;
    localparam logic [2:0] ST_RUN    = MODE_RUN;
    localparam logic [2:0] ST_PAUSE  = MODE_PAUSE;
    localparam logic [2:0] ST_FINISH = MODE_FINISH;
    localparam logic [2:0] ST_COUNT  = MODE_COUNT;

    // Button 3 advances / confirms / toggles pause.
    // Button 4 cancels / cycles difficulty / quits.
    localparam int unsigned BTN_ADVANCE = 3;
    localparam int unsigned BTN_CANCEL  = 4;

endpackage

// File: rtl/game_mode_ctrl_cycle_timer.sv
// ----------------------------------------------------------------------------
// cycle_timer
// Counts enabled clock cycles and raises a combinational one-cycle 'done'
// when LIMIT enabled cycles have elapsed since the last clear. The counter
// restarts after each done, so a continuously enabled timer fires every
// LIMIT cycles. LIMIT = 0 disables the timer (done never asserts).
// Ports:
//   clk    in  1  system clock
//   rst    in  1  asynchronous reset, active-high
//   clear  in  1  restart counting from zero at the next edge
//   en     in  1  count this cycle; while low the counter is held at zero
//   done   out 1  high during the LIMIT-th enabled cycle
// ----------------------------------------------------------------------------
module cycle_timer #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic done
);

    // Terminal count; the LIMIT==0 branch only keeps the constant in range.
    localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    assign done = (LIMIT != 0) && en && !clear && (cnt == LAST);

    // Holding the counter at zero whenever disabled means it is already
    // clean on the next entry and can never wrap while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !en || done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_mode_ctrl.sv
// ----------------------------------------------------------------------------
// game_mode_ctrl
// Top-level mode sequencer for the rhythm game:
// IDLE -> EDIT -> DIFF -> COUNT -> RUN <-> PAUSE -> FINISH -> IDLE.
// Driven by debounced one-cycle button pulses and the song-finished level.
// All outputs are registered.
// Ports:
//   clk         in   1       system clock (12 MHz)
//   rst         in   1       asynchronous reset, active-high
//   pushed_3    in   1       button 3 pulse: advance / confirm / pause toggle
//   pushed_4    in   1       button 4 pulse: cancel / cycle difficulty / quit
//   fin_check   in   1       song finished (level)
//   mode        out  3       current mode (game_pkg::mode_t encoding)
//   difficulty  out  DIFF_W  selected difficulty level
//   count_beat  out  CB_W    beats remaining during COUNT, else 0
//   game_start  out  1       pulse when the game actually starts running
//   game_over   out  1       pulse on the first cycle of FINISH
// ----------------------------------------------------------------------------
module game_mode_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DIFF_LEVELS   = 3,
    parameter int unsigned COUNT_BEATS   = 3,
    parameter int unsigned BEAT_CYCLES   = 12_000_000,
    parameter int unsigned PAUSE_TIMEOUT = 360_000_000,
    localparam int unsigned DIFF_W = (DIFF_LEVELS > 1) ? $clog2(DIFF_LEVELS) : 1,
    localparam int unsigned CB_W   = (COUNT_BEATS > 0) ? $clog2(COUNT_BEATS + 1) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pushed_3,
    input  logic              pushed_4,
    input  logic              fin_check,
    output logic [2:0]        mode,
    output logic [DIFF_W-1:0] difficulty,
    output logic [CB_W-1:0]   count_beat,
    output logic              game_start,
    output logic              game_over
);

    localparam int unsigned PRE_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int unsigned PT_W  = (PAUSE_TIMEOUT > 0) ? $clog2(PAUSE_TIMEOUT + 1) : 1;

    localparam logic [DIFF_W-1:0] DIFF_MAX = DIFF_W'(DIFF_LEVELS - 1);
    localparam logic [CB_W-1:0]   CB_LOAD  = CB_W'(COUNT_BEATS);

    logic [2:0]        mode_next;
    logic [DIFF_W-1:0] diff_next;
    logic [CB_W-1:0]   beat_next;
    logic              beat_done;
    logic              pause_done;
    logic              enter_count;
    logic              enter_pause;
    logic              start_next;
    logic              over_next;

    // Both timers restart on the edge that enters their mode, so every
    // COUNT and every PAUSE visit is timed from scratch.
    assign enter_count = (mode_next == ST_COUNT) && (mode != ST_COUNT);
    assign enter_pause = (mode_next == ST_PAUSE) && (mode != ST_PAUSE);

    cycle_timer #(
        .LIMIT (BEAT_CYCLES),
        .CNT_W (PRE_W)
    ) u_beat_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (enter_count),
        .en    (mode == ST_COUNT),
        .done  (beat_done)
    );

    cycle_timer #(
        .LIMIT (PAUSE_TIMEOUT),
        .CNT_W (PT_W)
    ) u_pause_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (enter_pause),
        .en    (mode == ST_PAUSE),
        .done  (pause_done)
    );

    // Next-state, difficulty and beat logic. Within each mode the checks are
    // ordered so the higher-priority event wins when several arrive together.
    always_comb begin
        mode_next = mode;
        diff_next = difficulty;
        beat_next = count_beat;
        case (mode)
            ST_IDLE: begin
                if (pushed_3) mode_next = ST_EDIT;
            end
            ST_EDIT: begin
                if (pushed_4)      mode_next = ST_IDLE;
                else if (pushed_3) mode_next = ST_DIFF;
            end
            ST_DIFF: begin
                if (pushed_3) begin
                    if (COUNT_BEATS == 0) begin
                        mode_next = ST_RUN;
                    end else begin
                        mode_next = ST_COUNT;
                        beat_next = CB_LOAD;
                    end
                end else if (pushed_4) begin
                    diff_next = (difficulty == DIFF_MAX) ? '0 : difficulty + DIFF_W'(1);
                end
            end
            ST_COUNT: begin
                // Buttons and fin_check are deliberately ignored here.
                if (beat_done) begin
                    if (count_beat <= CB_W'(1)) begin
                        mode_next = ST_RUN;
                        beat_next = '0;
                    end else begin
                        beat_next = count_beat - CB_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (fin_check)     mode_next = ST_FINISH;
                else if (pushed_3) mode_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pushed_4)        mode_next = ST_FINISH;
                else if (pushed_3)   mode_next = ST_RUN;
                else if (pause_done) mode_next = ST_FINISH;
            end
            ST_FINISH: begin
                if (pushed_3) mode_next = ST_IDLE;
            end
            default: begin
                mode_next = ST_IDLE;
            end
        endcase
    end

    // game_start fires only for the countdown (or skipped countdown) exit,
    // never for PAUSE -> RUN; game_over fires on any entry into FINISH.
    always_comb begin
        start_next = (mode_next == ST_RUN) &&
                     ((mode == ST_COUNT) || (mode == ST_DIFF));
        over_next  = (mode_next == ST_FINISH) && (mode != ST_FINISH);
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode       <= ST_IDLE;
            difficulty <= '0;
            count_beat <= '0;
            game_start <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            mode       <= mode_next;
            difficulty <= diff_next;
            count_beat <= beat_next;
            game_start <= start_next;
            game_over  <= over_next;
        end
    end

endmodule

// File: tb/tb_game_mode_ctrl.sv
// ----------------------------------------------------------------------------
// tb_game_mode_ctrl
// Directed and random stimulus for game_mode_ctrl, compared every cycle with
// a behavioural model that tracks elapsed cycles in COUNT and PAUSE.
// ----------------------------------------------------------------------------
module tb_game_mode_ctrl;

    localparam int unsigned DIFF_LEVELS   = 3;
    localparam int unsigned COUNT_BEATS   = 3;
    localparam int unsigned BEAT_CYCLES   = 4;
    localparam int unsigned PAUSE_TIMEOUT = 20;

    logic       clk;
    logic       rst;
    logic       pushed_3;
    logic       pushed_4;
    logic       fin_check;
    logic [2:0] mode;
    logic [1:0] difficulty;
    logic [1:0] count_beat;
    logic       game_start;
    logic       game_over;

    int total;
    int bad;

    // Reference model state (modes as the numbers 1..7).
    int m_mode;
    int m_diff;
    int m_count_elapsed;
    int m_pause_elapsed;
    int m_start;
    int m_over;

    game_mode_ctrl #(
        .DIFF_LEVELS   (DIFF_LEVELS),
        .COUNT_BEATS   (COUNT_BEATS),
        .BEAT_CYCLES   (BEAT_CYCLES),
        .PAUSE_TIMEOUT (PAUSE_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pushed_3   (pushed_3),
        .pushed_4   (pushed_4),
        .fin_check  (fin_check),
        .mode       (mode),
        .difficulty (difficulty),
        .count_beat (count_beat),
        .game_start (game_start),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode          = 1;
        m_diff          = 0;
        m_count_elapsed = 0;
        m_pause_elapsed = 0;
        m_start         = 0;
        m_over          = 0;
    endtask

    // One clock edge of the game rules.
    task automatic model_step(input bit p3, input bit p4, input bit fin);
        m_start = 0;
        m_over  = 0;
        case (m_mode)
            1: if (p3) m_mode = 2;
            2: begin
                if (p4)      m_mode = 1;
                else if (p3) m_mode = 3;
            end
            3: begin
                if (p3) begin
                    m_mode = 7;
                    m_count_elapsed = 0;
                end else if (p4) begin
                    m_diff = (m_diff + 1) % DIFF_LEVELS;
                end
            end
            7: begin
                m_count_elapsed++;
                if (m_count_elapsed == COUNT_BEATS * BEAT_CYCLES) begin
                    m_mode  = 4;
                    m_start = 1;
                end
            end
            4: begin
                if (fin) begin
                    m_mode = 6;
                    m_over = 1;
                end else if (p3) begin
                    m_mode = 5;
                    m_pause_elapsed = 0;
                end
            end
            5: begin
                m_pause_elapsed++;
                if (p4) begin
                    m_mode = 6;
                    m_over = 1;
                end else if (p3) begin
                    m_mode = 4;
                end else if (m_pause_elapsed == PAUSE_TIMEOUT) begin
                    m_mode = 6;
                    m_over = 1;
                end
            end
            6: if (p3) m_mode = 1;
            default: m_mode = 1;
        endcase
    endtask

    function automatic int model_beat();
        if (m_mode == 7) return COUNT_BEATS - (m_count_elapsed / BEAT_CYCLES);
        return 0;
    endfunction

    task automatic check_one(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_output(input string tag);
        check_one({tag, ".mode"},       {5'd0, mode},       8'(m_mode));
        check_one({tag, ".difficulty"}, {6'd0, difficulty}, 8'(m_diff));
        check_one({tag, ".count_beat"}, {6'd0, count_beat}, 8'(model_beat()));
        check_one({tag, ".game_start"}, {7'd0, game_start}, 8'(m_start));
        check_one({tag, ".game_over"},  {7'd0, game_over},  8'(m_over));
    endtask

    // Called at a negedge: drive one cycle of inputs, let the edge happen,
    // then compare at the following negedge.
    task automatic apply_stimulus(input bit p3, input bit p4, input bit fin, input string tag);
        pushed_3  = p3;
        pushed_4  = p4;
        fin_check = fin;
        @(posedge clk);
        model_step(p3, p4, fin);
        @(negedge clk);
        pushed_3  = 1'b0;
        pushed_4  = 1'b0;
        fin_check = 1'b0;
        check_output(tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, tag);
    endtask

    // Reset asserted between edges must act at once.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_output(tag);
        @(negedge clk);
        rst = 1'b0;
        check_output({tag, "_held"});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        pushed_3  = 1'b0;
        pushed_4  = 1'b0;
        fin_check = 1'b0;
        model_reset();

        // Reset between clock edges.
        @(negedge clk);
        async_reset("reset");

        // Start a game, countdown with ignored inputs.
        apply_stimulus(1'b1, 1'b0, 1'b0, "to_edit");
        apply_stimulus(1'b1, 1'b0, 1'b0, "to_diff");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 1'b0, "diff_cycle");
        apply_stimulus(1'b1, 1'b1, 1'b0, "diff_both");
        for (int i = 0; i < 12; i++)
            apply_stimulus(i[0], (i % 3) == 0, (i % 4) == 1, "count_ignore");
        apply_stimulus(1'b0, 1'b0, 1'b0, "run_settle");

        // Finish beats pause, finish ignores fin level, back to idle.
        apply_stimulus(1'b1, 1'b0, 1'b1, "run_fin_p3");
        apply_stimulus(1'b0, 1'b0, 1'b1, "finish_hold");
        apply_stimulus(1'b1, 1'b0, 1'b0, "finish_idle");

        // Pause resumed on the expiry cycle, then a full timeout.
        apply_stimulus(1'b1, 1'b0, 1'b0, "g2_edit");
        apply_stimulus(1'b1, 1'b0, 1'b0, "g2_diff");
        apply_stimulus(1'b1, 1'b0, 1'b0, "g2_count");
        idle_cycles(12, "g2_countdown");
        apply_stimulus(1'b1, 1'b0, 1'b0, "pause1");
        idle_cycles(19, "pause1_wait");
        apply_stimulus(1'b1, 1'b0, 1'b0, "resume_at_expiry");
        apply_stimulus(1'b1, 1'b0, 1'b0, "pause2");
        idle_cycles(20, "pause_timeout");
        apply_stimulus(1'b1, 1'b0, 1'b0, "g2_idle");

        // Quit from pause with both buttons.
        apply_stimulus(1'b1, 1'b0, 1'b0, "g3_edit");
        apply_stimulus(1'b1, 1'b0, 1'b0, "g3_diff");
        apply_stimulus(1'b1, 1'b0, 1'b0, "g3_count");
        idle_cycles(12, "g3_countdown");
        apply_stimulus(1'b1, 1'b0, 1'b0, "g3_pause");
        apply_stimulus(1'b1, 1'b1, 1'b0, "pause_quit");
        apply_stimulus(1'b1, 1'b0, 1'b0, "g3_idle");

        // Cancel from EDIT, then reset in the middle of a countdown.
        apply_stimulus(1'b1, 1'b0, 1'b0, "g4_edit");
        apply_stimulus(1'b0, 1'b1, 1'b0, "edit_cancel");
        apply_stimulus(1'b1, 1'b0, 1'b0, "g4_edit2");
        apply_stimulus(1'b1, 1'b0, 1'b0, "g4_diff");
        apply_stimulus(1'b1, 1'b0, 1'b0, "g4_count");
        idle_cycles(5, "g4_countdown");
        async_reset("reset_mid_count");
        idle_cycles(3, "after_reset");

        // Random walk through all modes.
        for (int i = 0; i < 600; i++) begin
            apply_stimulus(($urandom % 4) == 0, ($urandom % 5) == 0,
                           ($urandom % 8) == 0, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
